// File: rtl/simple_bus_mem_slave.sv
// simple_bus_mem_slave
//   Slave end of the simple_bus protocol: a byte-wide memory servicing single
//   read, single write and burst-read transactions.
//
// Ports
//   clk, rst        bus clock; asynchronous active-high reset
//   req  / gnt      master bus request / registered slave grant
//   addr, mode      transaction address and type (00 rd, 01 wr, 10 burst rd, 11 reserved)
//   start           qualifies addr/mode/data_i while gnt=1
//   rdy             one beat completes in this cycle
//   data_i          write data from the master
//   data_o, data_oe read data and its drive enable (high on read-beat rdy cycles only)
//   err             error response, meaningful only while rdy=1
//
// Handshake: the master raises req and holds it until it sees gnt. A command
// is accepted on any rising edge where the slave is GRANTED and start=1; that
// edge captures addr/mode/data_i and ends the grant. The slave then answers
// with one rdy beat (or BURST_LEN consecutive beats for a burst) and the master
// cannot stall them: every rdy cycle is a completed beat.
module simple_bus_mem_slave #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1,
  parameter int BURST_LEN   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  output logic       gnt,
  input  logic [7:0] addr,
  input  logic [1:0] mode,
  input  logic       start,
  output logic       rdy,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe,
  output logic       err
);

  localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W    = 9'(DEPTH);
  localparam logic [3:0] WAIT_LAST  = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
  localparam logic [3:0] BEAT_LAST  = 4'(BURST_LEN - 1);
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANTED,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  state_t     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic [7:0] addr_q, addr_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] wdata_q, wdata_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [3:0] beat_q, beat_d;

  logic [7:0] mem_q [DEPTH];
  logic       mem_we;

  logic [7:0] beat_addr;
  logic       beat_in_range;
  logic       addr_in_range;

  // Single transfers keep beat_q at zero, so beat_addr is the captured
  // address for them; bursts walk it with natural 8-bit wrap.
  assign beat_addr     = addr_q + {4'd0, beat_q};
  assign beat_in_range = ({1'b0, beat_addr} < DEPTH_W);
  assign addr_in_range = ({1'b0, addr} < DEPTH_W);

  assign gnt = gnt_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mode_d     = mode_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    beat_d     = beat_q;
    mem_we     = 1'b0;
    rdy        = 1'b0;
    data_o     = 8'h00;
    data_oe    = 1'b0;
    err        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) state_d = S_GRANTED;
      end

      S_GRANTED: begin
        // start wins over a simultaneous req drop.
        if (start) begin
          addr_d     = addr;
          mode_d     = mode;
          wdata_d    = data_i;
          wait_cnt_d = 4'd0;
          beat_d     = 4'd0;
          if (mode == MODE_RSVD || !addr_in_range) state_d = S_ERR;
          else if (WAIT_CYCLES == 0)               state_d = S_RESP;
          else                                     state_d = S_WAIT;
        end else if (!req) begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = S_RESP;
        else                         wait_cnt_d = wait_cnt_q + 4'd1;
      end

      S_RESP: begin
        rdy = 1'b1;
        case (mode_q)
          MODE_WRITE: begin
            mem_we  = 1'b1;
            state_d = S_IDLE;
          end
          MODE_BURST: begin
            data_oe = 1'b1;
            // Beats past the end of memory report err but keep the burst length.
            if (beat_in_range) data_o = mem_q[beat_addr[AW-1:0]];
            else               err    = 1'b1;
            if (beat_q == BEAT_LAST) state_d = S_IDLE;
            else                     beat_d  = beat_q + 4'd1;
          end
          default: begin
            data_oe = 1'b1;
            data_o  = mem_q[beat_addr[AW-1:0]];
            state_d = S_IDLE;
          end
        endcase
      end

      S_ERR: begin
        rdy     = 1'b1;
        err     = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Grant is a registered decode of the next state, never a path from req.
    gnt_d = (state_d == S_GRANTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      addr_q     <= 8'h00;
      mode_q     <= 2'b00;
      wdata_q    <= 8'h00;
      wait_cnt_q <= 4'd0;
      beat_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      mode_q     <= mode_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      beat_q     <= beat_d;
    end
  end

  // Writes only reach memory at the end of the write rdy cycle, so a reset
  // landing earlier in the transaction discards the pending data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[addr_q[AW-1:0]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_simple_bus_mem_slave.sv
// tb_simple_bus_mem_slave
//   Directed bench for simple_bus_mem_slave. Two instances share the bus
//   inputs: dut_a uses the defaults (DEPTH=256, WAIT_CYCLES=1, BURST_LEN=4),
//   dut_b uses DEPTH=128, WAIT_CYCLES=0. use_b selects which one is observed.
module tb_simple_bus_mem_slave;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       start;
  logic [7:0] addr;
  logic [1:0] mode;
  logic [7:0] data_i;

  logic       gnt_a, rdy_a, oe_a, err_a;
  logic [7:0] dout_a;
  logic       gnt_b, rdy_b, oe_b, err_b;
  logic [7:0] dout_b;

  logic       use_b;
  logic       cur_gnt, cur_rdy, cur_oe, cur_err;
  logic [7:0] cur_dout;

  assign cur_gnt  = use_b ? gnt_b  : gnt_a;
  assign cur_rdy  = use_b ? rdy_b  : rdy_a;
  assign cur_oe   = use_b ? oe_b   : oe_a;
  assign cur_err  = use_b ? err_b  : err_a;
  assign cur_dout = use_b ? dout_b : dout_a;

  always #5 clk = ~clk;

  simple_bus_mem_slave #(.DEPTH(256), .WAIT_CYCLES(1), .BURST_LEN(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_a), .addr(addr), .mode(mode),
    .start(start), .rdy(rdy_a), .data_i(data_i), .data_o(dout_a),
    .data_oe(oe_a), .err(err_a)
  );

  simple_bus_mem_slave #(.DEPTH(128), .WAIT_CYCLES(0), .BURST_LEN(4)) dut_b (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_b), .addr(addr), .mode(mode),
    .start(start), .rdy(rdy_b), .data_i(data_i), .data_o(dout_b),
    .data_oe(oe_b), .err(err_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Beats observed by the last bus_txn; cyc counts negedges after the accept edge.
  int         beat_cnt;
  logic [7:0] bd  [16];
  logic       bo  [16];
  logic       be  [16];
  int         bc  [16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_gnt(output bit granted);
    granted = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cur_gnt) begin
        granted = 1'b1;
        break;
      end
    end
    if (!granted) begin
      n_checks++;
      $display("FAIL gnt_timeout: gnt stayed 0, required 1 within 10 cycles");
    end
  endtask

  task automatic bus_txn(input logic [1:0] m, input logic [7:0] a, input logic [7:0] d);
    bit granted;
    beat_cnt = 0;
    @(posedge clk); #1;
    req = 1'b1;
    wait_gnt(granted);
    if (granted) begin
      start  = 1'b1;
      mode   = m;
      addr   = a;
      data_i = d;
      req    = 1'b0;
      @(posedge clk); #1;
      start  = 1'b0;
      data_i = 8'hFF;
      addr   = 8'hFF;
      mode   = 2'b00;
      for (int c = 1; c <= 24; c++) begin
        @(negedge clk);
        if (cur_rdy && beat_cnt < 16) begin
          bd[beat_cnt] = cur_dout;
          bo[beat_cnt] = cur_oe;
          be[beat_cnt] = cur_err;
          bc[beat_cnt] = c;
          beat_cnt++;
        end
      end
    end else begin
      req = 1'b0;
    end
  endtask

  // ---------------- test tasks ----------------
  task automatic test_reset();
    bit granted;
    use_b = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (gnt_a !== 1'b0)   $display("FAIL rst_gnt: got %b want 0", gnt_a);   else n_pass++;
    n_checks++; if (rdy_a !== 1'b0)   $display("FAIL rst_rdy: got %b want 0", rdy_a);   else n_pass++;
    n_checks++; if (err_a !== 1'b0)   $display("FAIL rst_err: got %b want 0", err_a);   else n_pass++;
    n_checks++; if (oe_a !== 1'b0)    $display("FAIL rst_oe: got %b want 0", oe_a);     else n_pass++;
    n_checks++; if (dout_a !== 8'h00) $display("FAIL rst_dout: got %h want 00", dout_a); else n_pass++;
    rst = 1'b0;

    // Reset while granted drops gnt without waiting for a clock edge.
    @(posedge clk); #1;
    req = 1'b1;
    wait_gnt(granted);
    rst = 1'b1;
    #1;
    n_checks++; if (gnt_a !== 1'b0) $display("FAIL rst_async_gnt: got %b want 0", gnt_a); else n_pass++;
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Reset during the wait state of a write: the write must be lost.
    @(posedge clk); #1;
    req = 1'b1;
    wait_gnt(granted);
    start = 1'b1; mode = 2'b01; addr = 8'h10; data_i = 8'hA5; req = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (gnt_a !== 1'b0 || rdy_a !== 1'b0 || oe_a !== 1'b0)
      $display("FAIL rst_mid_wait_outputs: got gnt=%b rdy=%b oe=%b want 0 0 0", gnt_a, rdy_a, oe_a);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_txn(2'b00, 8'h10, 8'h00);
    n_checks++; if (beat_cnt !== 1) $display("FAIL rst_readback_beats: got %0d want 1", beat_cnt); else n_pass++;
    n_checks++; if (bd[0] !== 8'h00) $display("FAIL rst_readback_data: got %h want 00", bd[0]); else n_pass++;
  endtask

  task automatic test_write_read();
    use_b = 1'b0;
    bus_txn(2'b01, 8'h20, 8'h3C);
    n_checks++; if (beat_cnt !== 1) $display("FAIL wr_beats: got %0d want 1", beat_cnt); else n_pass++;
    n_checks++; if (bc[0] !== 2)    $display("FAIL wr_latency: rdy at cycle %0d want 2", bc[0]); else n_pass++;
    n_checks++; if (bo[0] !== 1'b0) $display("FAIL wr_oe: got %b want 0", bo[0]); else n_pass++;
    n_checks++; if (be[0] !== 1'b0) $display("FAIL wr_err: got %b want 0", be[0]); else n_pass++;

    bus_txn(2'b00, 8'h20, 8'h00);
    n_checks++; if (beat_cnt !== 1)  $display("FAIL rd_beats: got %0d want 1", beat_cnt); else n_pass++;
    n_checks++; if (bc[0] !== 2)     $display("FAIL rd_latency: rdy at cycle %0d want 2", bc[0]); else n_pass++;
    n_checks++; if (bd[0] !== 8'h3C) $display("FAIL rd_data: got %h want 3c", bd[0]); else n_pass++;
    n_checks++; if (bo[0] !== 1'b1)  $display("FAIL rd_oe: got %b want 1", bo[0]); else n_pass++;
    n_checks++; if (be[0] !== 1'b0)  $display("FAIL rd_err: got %b want 0", be[0]); else n_pass++;
  endtask

  task automatic test_burst_wrap();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    use_b = 1'b0;
    bus_txn(2'b01, 8'hFE, 8'h11);
    bus_txn(2'b01, 8'hFF, 8'h22);
    bus_txn(2'b01, 8'h00, 8'h33);
    bus_txn(2'b01, 8'h01, 8'h44);
    bus_txn(2'b10, 8'hFE, 8'h00);
    n_checks++; if (beat_cnt !== 4) $display("FAIL burst_beats: got %0d want 4", beat_cnt); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bd[k] !== exp_d[k]) $display("FAIL burst_data[%0d]: got %h want %h", k, bd[k], exp_d[k]); else n_pass++;
      n_checks++; if (bc[k] !== 2 + k)    $display("FAIL burst_cycle[%0d]: got %0d want %0d", k, bc[k], 2 + k); else n_pass++;
      n_checks++; if (be[k] !== 1'b0)     $display("FAIL burst_err[%0d]: got %b want 0", k, be[k]); else n_pass++;
      n_checks++; if (bo[k] !== 1'b1)     $display("FAIL burst_oe[%0d]: got %b want 1", k, bo[k]); else n_pass++;
    end
  endtask

  task automatic test_errors();
    logic [7:0] exp_d [4];
    logic       exp_e [4];
    exp_d[0] = 8'h5A; exp_d[1] = 8'h6B; exp_d[2] = 8'h00; exp_d[3] = 8'h00;
    exp_e[0] = 1'b0;  exp_e[1] = 1'b0;  exp_e[2] = 1'b1;  exp_e[3] = 1'b1;

    // Reserved mode on dut_a: one error beat, memory at 0x20 untouched.
    use_b = 1'b0;
    bus_txn(2'b11, 8'h20, 8'h77);
    n_checks++; if (beat_cnt !== 1)  $display("FAIL rsvd_beats: got %0d want 1", beat_cnt); else n_pass++;
    n_checks++; if (be[0] !== 1'b1)  $display("FAIL rsvd_err: got %b want 1", be[0]); else n_pass++;
    n_checks++; if (bo[0] !== 1'b0)  $display("FAIL rsvd_oe: got %b want 0", bo[0]); else n_pass++;
    n_checks++; if (bd[0] !== 8'h00) $display("FAIL rsvd_data: got %h want 00", bd[0]); else n_pass++;
    bus_txn(2'b00, 8'h20, 8'h00);
    n_checks++; if (bd[0] !== 8'h3C) $display("FAIL rsvd_mem_kept: got %h want 3c", bd[0]); else n_pass++;

    // Out-of-range read on the 128-word instance.
    use_b = 1'b1;
    bus_txn(2'b00, 8'h80, 8'h00);
    n_checks++; if (beat_cnt !== 1)  $display("FAIL oor_beats: got %0d want 1", beat_cnt); else n_pass++;
    n_checks++; if (be[0] !== 1'b1)  $display("FAIL oor_err: got %b want 1", be[0]); else n_pass++;
    n_checks++; if (bd[0] !== 8'h00) $display("FAIL oor_data: got %h want 00", bd[0]); else n_pass++;
    n_checks++; if (bo[0] !== 1'b0)  $display("FAIL oor_oe: got %b want 0", bo[0]); else n_pass++;

    // Burst crossing the end of the 128-word memory.
    bus_txn(2'b01, 8'h7E, 8'h5A);
    bus_txn(2'b01, 8'h7F, 8'h6B);
    bus_txn(2'b10, 8'h7E, 8'h00);
    n_checks++; if (beat_cnt !== 4) $display("FAIL edge_burst_beats: got %0d want 4", beat_cnt); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bd[k] !== exp_d[k]) $display("FAIL edge_burst_data[%0d]: got %h want %h", k, bd[k], exp_d[k]); else n_pass++;
      n_checks++; if (be[k] !== exp_e[k]) $display("FAIL edge_burst_err[%0d]: got %b want %b", k, be[k], exp_e[k]); else n_pass++;
      n_checks++; if (bc[k] !== 1 + k)    $display("FAIL edge_burst_cycle[%0d]: got %0d want %0d", k, bc[k], 1 + k); else n_pass++;
    end
  endtask

  task automatic test_grant_withdraw();
    int g_cnt = 0;
    int r_cnt = 0;
    use_b = 1'b0;
    @(posedge clk); #1;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (gnt_a) g_cnt++;
      if (rdy_a) r_cnt++;
    end
    n_checks++; if (g_cnt !== 1) $display("FAIL withdraw_gnt_cycles: got %0d want 1", g_cnt); else n_pass++;
    n_checks++; if (r_cnt !== 0) $display("FAIL withdraw_rdy_cycles: got %0d want 0", r_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit granted;
    int rdy1_cyc = -1;
    int gnt2_cyc = -1;
    int r2_cnt   = 0;
    use_b = 1'b1;
    @(posedge clk); #1;
    req = 1'b1;
    wait_gnt(granted);
    start = 1'b1; mode = 2'b01; addr = 8'h30; data_i = 8'hC3;
    @(posedge clk); #1;
    start = 1'b0; data_i = 8'hFF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (cur_rdy && rdy1_cyc < 0) rdy1_cyc = c;
      if (cur_gnt && rdy1_cyc >= 0) begin
        gnt2_cyc = c;
        break;
      end
    end
    n_checks++; if (rdy1_cyc !== 1) $display("FAIL b2b_first_rdy: cycle %0d want 1", rdy1_cyc); else n_pass++;
    n_checks++; if (gnt2_cyc - rdy1_cyc !== 2)
      $display("FAIL b2b_turnaround: gnt %0d cycles after rdy, want 2", gnt2_cyc - rdy1_cyc);
    else n_pass++;
    start = 1'b1; mode = 2'b01; addr = 8'h31; data_i = 8'h3D; req = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; data_i = 8'hFF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (cur_rdy) r2_cnt++;
    end
    n_checks++; if (r2_cnt !== 1) $display("FAIL b2b_second_rdy: got %0d beats want 1", r2_cnt); else n_pass++;
    bus_txn(2'b00, 8'h30, 8'h00);
    n_checks++; if (bd[0] !== 8'hC3) $display("FAIL b2b_read30: got %h want c3", bd[0]); else n_pass++;
    bus_txn(2'b00, 8'h31, 8'h00);
    n_checks++; if (bd[0] !== 8'h3D) $display("FAIL b2b_read31: got %h want 3d", bd[0]); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst    = 1'b1;
    req    = 1'b0;
    start  = 1'b0;
    addr   = 8'h00;
    mode   = 2'b00;
    data_i = 8'h00;
    use_b  = 1'b0;
    test_reset();
    test_write_read();
    test_burst_wrap();
    test_errors();
    test_grant_withdraw();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
